fact_bcd_streamer: RTL and testbench

Downstream stage of the factorial block. It captures each new factorial result (up to 46 bits) and converts it to BCD with a sequential double-dabble engine, one shift per cycle. It then streams the decimal digits, most significant first, over a valid/ready handshake to the display/UART formatter. The upstream block holds its valid high after completion, so this block starts only on a rising edge of that valid.

---
 rtl/fact_pkg.sv | 17 +
 rtl/bcd_add3.sv | 11 +
 rtl/fact_bcd_streamer.sv | 116 +++++++++++
 tb/tb_fact_bcd_streamer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fact_pkg.sv
// Shared types and sizing for the factorial result path and its BCD streamer.
package fact_pkg;

  localparam int FACT_W     = 46;
  localparam int BCD_DIGITS = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    EMIT = 2'd2,
    SKIP = 2'd3
  } state_e;

  typedef logic [3:0]                  bcd_digit_t;
  typedef bcd_digit_t [BCD_DIGITS-1:0] bcd_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 before the next shift.
module bcd_add3
  import fact_pkg::*;
(
  input  bcd_digit_t digit_i,
  output bcd_digit_t digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/fact_bcd_streamer.sv
// Captures a binary factorial result on a rising in_valid, converts it to BCD one
// shift per cycle and streams the digits MSD first. Optional: BCD_LZ_SUPPRESS_EN.
module fact_bcd_streamer
  import fact_pkg::*;
#(
  parameter int DATA_W = FACT_W,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [3:0]        out_digit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              out_busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_e                   state_q, state_d;
  logic                     in_valid_q;
  logic [DATA_W-1:0]        bin_q, bin_d;
  logic [DIGITS-1:0][3:0]   bcd_q, bcd_d;
  logic [DIGITS-1:0][3:0]   bcd_adj;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     start;

  // The edge detector runs in every state so a level held across a conversion
  // can never masquerade as a new request once the block is idle again.
  assign start = in_valid && !in_valid_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_i (bcd_q[g]),
      .digit_o (bcd_adj[g])
    );
  end

  // NOTE: every target is given its current value first, so no path through the
  // case statement leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          bin_d   = in_data;
          bcd_d   = '0;
          cnt_d   = CNT_W'(DATA_W);
          state_d = CONV;
        end
      end
      CONV: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d          = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          idx_d   = IDX_W'(DIGITS - 1);
          state_d = EMIT;
`ifdef BCD_LZ_SUPPRESS_EN
          // Enter SKIP only when the top digit is already a leading zero, so a
          // non-zero MSD costs no extra cycle.
          if (bcd_d[DIGITS-1] == 4'd0) state_d = SKIP;
`endif
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (idx_q == '0) state_d = IDLE;
          else             idx_d   = idx_q - IDX_W'(1);
        end
      end
`ifdef BCD_LZ_SUPPRESS_EN
      SKIP: begin
        idx_d = idx_q - IDX_W'(1);
        if (bcd_q[idx_q - IDX_W'(1)] != 4'd0 || idx_q == IDX_W'(1)) state_d = EMIT;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; the datapath registers are reset too so an aborted conversion
  // leaves nothing behind.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      in_valid_q <= 1'b0;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_valid_q <= in_valid;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
    end
  end

  // Outputs decode straight from registers, so they hold steady through a stall.
  assign out_valid = (state_q == EMIT);
  assign out_digit = out_valid ? bcd_q[idx_q] : 4'd0;
  assign out_last  = out_valid && (idx_q == '0);
  assign out_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_fact_bcd_streamer.sv
// Self-checking bench for fact_bcd_streamer: directed and random values checked
// against a decimal-digit model, with stalls, retrigger and reset-abort scenarios.
module tb_fact_bcd_streamer;
  import fact_pkg::*;

  localparam int DW = FACT_W;
  localparam int ND = BCD_DIGITS;

  logic          clk;
  logic          resetn;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic [3:0]    out_digit;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          out_busy;

  int errors = 0;
  int checks = 0;

  fact_bcd_streamer dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_digit (out_digit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_busy  (out_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Decimal digits of v, most significant first, using plain division.
  task automatic model(input logic [DW-1:0] v, output int q[$]);
    longint unsigned x;
    int d[ND];
    x = 64'(v);
    for (int i = ND - 1; i >= 0; i--) begin
      d[i] = int'(x % 10);
      x    = x / 10;
    end
    q = {};
    for (int i = 0; i < ND; i++) q.push_back(d[i]);
`ifdef BCD_LZ_SUPPRESS_EN
    while (q.size() > 1 && q[0] == 0) void'(q.pop_front());
`endif
  endtask

  // mode: 0 = ready always high, 1 = ready pattern 1,0,0,..., 2 = random ready.
  task automatic run_conv(input logic [DW-1:0] value, input int mode,
                          input bit hold, input bit glitch);
    int   exp_q[$];
    int   n, cyc, r, glitch_cyc;
    bit   done, stalled, first_seen, rdy;
    logic [3:0] held_digit;
    logic       held_last;
    model(value, exp_q);
    @(negedge clk);
    in_data  = value;
    in_valid = 1'b1;
    @(posedge clk);
    n = 0; cyc = 0; r = 0; glitch_cyc = -1;
    done = 0; stalled = 0; first_seen = 0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (!hold && cyc == 2) in_valid = 1'b0;
      if (glitch_cyc >= 0 && cyc == glitch_cyc + 1) in_valid = 1'b0;
      if (cyc == 1) check("busy_after_start", out_busy, 1);
      if (stalled) begin
        check("stall_valid", out_valid, 1);
        check("stall_digit", out_digit, held_digit);
        check("stall_last", out_last, held_last);
      end
      out_ready = 1'b1;
      if (out_valid) begin
        if (!first_seen) begin
          first_seen = 1;
`ifndef BCD_LZ_SUPPRESS_EN
          check("first_valid_latency", cyc, DW + 1);
`endif
          if (glitch) begin
            in_valid   = 1'b1;
            glitch_cyc = cyc;
          end
        end
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = (r % 3 == 0);
          default: rdy = 1'($urandom);
        endcase
        r++;
        out_ready = rdy;
        if (rdy) begin
          check("digit", out_digit, (n < exp_q.size()) ? exp_q[n] : -1);
          check("last", out_last, (n == exp_q.size() - 1));
          n++;
          stalled = 0;
          if (n >= exp_q.size()) done = 1;
        end else begin
          stalled    = 1;
          held_digit = out_digit;
          held_last  = out_last;
        end
      end
    end
    if (!done) check("conv_timeout", 0, 1);
`ifndef BCD_LZ_SUPPRESS_EN
    if (done && mode == 0) check("last_digit_cycle", cyc, DW + ND);
`endif
    @(negedge clk);
    out_ready = 1'b1;
    check("busy_after_last", out_busy, 0);
    check("valid_after_last", out_valid, 0);
  endtask

  initial begin
    int bad;
    bit seen;
    resetn    = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1 resetn = 1'b0;
    #3;
    check("rst_digit", out_digit, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last",  out_last,  0);
    check("rst_busy",  out_busy,  0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", out_busy, 0);

    run_conv(46'd1307674368000, 0, 0, 0);
    run_conv({DW{1'b1}}, 0, 0, 0);
    run_conv('0, 0, 0, 0);
    run_conv(46'd120, 1, 0, 0);

    for (int k = 0; k < 4; k++) begin
      logic [DW-1:0] v;
      v = DW'({$urandom, $urandom});
      if (k[0]) v = DW'($urandom_range(0, 99999));
      run_conv(v, 2, 0, 0);
    end

    // Held-high request: one conversion only across 200 cycles.
    run_conv(46'd5040, 0, 1, 0);
    bad = 0;
    repeat (135) begin
      @(negedge clk);
      if (out_busy || out_valid) bad++;
    end
    check("held_no_retrigger", bad, 0);
    in_valid = 1'b0;
    @(negedge clk);

    // Rising edge during EMIT is ignored.
    run_conv(46'd362880, 1, 0, 1);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_busy) bad++;
    end
    check("emit_edge_ignored", bad, 0);
    run_conv(46'd87178291200, 2, 0, 0);

    // Asynchronous reset at the third emitted digit of 15!.
    @(negedge clk);
    in_data  = 46'd1307674368000;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("abort_reach_emit", seen, 1);
    repeat (2) @(negedge clk);
`ifndef BCD_LZ_SUPPRESS_EN
    check("abort_third_digit", out_digit, 3);
`endif
    resetn = 1'b0;
    #1;
    check("abort_digit", out_digit, 0);
    check("abort_valid", out_valid, 0);
    check("abort_last",  out_last,  0);
    check("abort_busy",  out_busy,  0);
    @(negedge clk);
    resetn = 1'b1;
    bad = 0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid || out_busy) bad++;
    end
    check("abort_no_more_digits", bad, 0);
    run_conv(46'd120, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
